// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout capture stage.
// Black-level subtraction is enabled by defining PIXEL_READOUT_BLACK_LEVEL_EN.
package pixel_readout_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        G1 = 2'd0,
        G2 = 2'd1,
        R  = 2'd2,
        B  = 2'd3
    } chan_e;

    typedef enum logic [1:0] {
        EXP1 = 2'd0,
        EXP2 = 2'd1,
        EXP3 = 2'd2,
        EXP4 = 2'd3
    } cap_state_e;

    // Saturating subtract: a borrow out of bit 8 means the result went negative.
    function automatic pixel_t black_sub(input pixel_t raw, input pixel_t level);
        logic [8:0] diff;
        diff = {1'b0, raw} - {1'b0, level};
        return diff[8] ? 8'd0 : diff[7:0];
    endfunction

endpackage

// File: rtl/pixel_frame_buf.sv
// Ping-pong frame store: two banks of four pixels, full flags, and the
// registered valid/ready output beat stage that drains the oldest full bank.
module pixel_frame_buf
    import pixel_readout_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_slot,
    input  pixel_t     i_wr_data,
    input  logic       i_mark_full,
    output logic       o_wr_full,
    input  logic       i_out_ready,
    output logic       o_out_valid,
    output pixel_t     o_out_data,
    output logic [1:0] o_out_chan,
    output logic       o_out_first,
    output logic       o_out_last,
    output logic       o_frame_done
);

    pixel_t     r_mem [0:1][0:3];
    logic [1:0] r_full;
    logic       r_wbank;
    logic       r_rbank;
    logic       r_fbank;
    logic [1:0] r_fslot;
    logic       r_out_valid;
    pixel_t     r_out_data;
    logic [1:0] r_out_chan;
    logic       r_out_first;
    logic       r_out_last;
    logic       r_frame_done;

    logic       w_load;
    logic       w_avail;
    logic       w_last_hs;
    logic [1:0] w_set;
    logic [1:0] w_clr;

    // The fetch pointer runs ahead of the handshake pointer; a bank stays full until its last beat is accepted.
    assign w_load    = !r_out_valid || i_out_ready;
    assign w_avail   = r_full[r_fbank];
    assign w_last_hs = r_out_valid && i_out_ready && r_out_last;
    assign w_set     = i_mark_full ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr     = w_last_hs   ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

    // Pixel storage write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wbank][i_wr_slot] <= i_wr_data;
        end
    end

    // Bank flags, pointers and the output beat register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full       <= 2'b00;
            r_wbank      <= 1'b0;
            r_rbank      <= 1'b0;
            r_fbank      <= 1'b0;
            r_fslot      <= 2'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'd0;
            r_out_chan   <= 2'd0;
            r_out_first  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_full       <= (r_full & ~w_clr) | w_set;
            r_frame_done <= w_last_hs;
            if (i_mark_full) begin
                r_wbank <= ~r_wbank;
            end
            if (w_last_hs) begin
                r_rbank <= ~r_rbank;
            end
            if (w_load) begin
                r_out_valid <= w_avail;
                if (w_avail) begin
                    r_out_data  <= r_mem[r_fbank][r_fslot];
                    r_out_chan  <= r_fslot;
                    r_out_first <= (r_fslot == 2'd0);
                    r_out_last  <= (r_fslot == 2'd3);
                    r_fslot     <= r_fslot + 2'd1;
                    if (r_fslot == 2'd3) begin
                        r_fbank <= ~r_fbank;
                    end
                end
            end
        end
    end

    assign o_wr_full    = r_full[r_wbank];
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_chan   = r_out_chan;
    assign o_out_first  = r_out_first;
    assign o_out_last   = r_out_last;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/pixel_readout.sv
// Pixel readout top: strobe edge detection, capture sequencer and counters.
// Define PIXEL_READOUT_BLACK_LEVEL_EN to subtract BLACK_LEVEL from each pixel.
module pixel_readout
    import pixel_readout_pkg::*;
#(
    parameter pixel_t BLACK_LEVEL = 8'd0,
    parameter int     CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read1,
    input  logic             read2,
    input  logic             read3,
    input  logic             read4,
    input  pixel_t           DATA,
    output logic             out_valid,
    input  logic             out_ready,
    output pixel_t           out_data,
    output logic [1:0]       out_chan,
    output logic             out_first,
    output logic             out_last,
    output logic             seq_err,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    cap_state_e       r_state;
    cap_state_e       w_state_n;
    logic [3:0]       r_read_d;
    pixel_t           r_hold;
    logic             r_ignore;
    logic             r_dropping;
    logic             r_seq_err;
    logic             r_overflow;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [3:0]       w_read;
    logic [3:0]       w_fall;
    logic             w_multi;
    logic             w_commit;
    logic [1:0]       w_slot;
    pixel_t           w_value;
    logic             w_drop_n;
    logic             w_wr_en;
    logic             w_mark;
    logic             w_seq_n;
    logic             w_ovf_n;
    logic             w_wr_full;
    logic             w_frame_done;

    assign w_read  = {read4, read3, read2, read1};
    assign w_fall  = r_read_d & ~w_read;
    assign w_multi = (w_read & (w_read - 4'd1)) != 4'd0;
    // Strobes that overlapped are already counted as an error; their falling edges must not commit.
    assign w_commit = (w_fall != 4'd0) && !r_ignore && !w_multi;

`ifdef PIXEL_READOUT_BLACK_LEVEL_EN
    assign w_value = black_sub(r_hold, BLACK_LEVEL);
`else
    logic w_unused_bl;
    assign w_unused_bl = ^BLACK_LEVEL;
    assign w_value     = r_hold;
`endif

    // Slot index of the strobe that just fell.
    always_comb begin
        w_slot = 2'd0;
        case (w_fall)
            4'b0001: w_slot = 2'd0;
            4'b0010: w_slot = 2'd1;
            4'b0100: w_slot = 2'd2;
            4'b1000: w_slot = 2'd3;
            default: w_slot = 2'd0;
        endcase
    end

    // Capture sequencer next-state and commit decisions.
    always_comb begin
        w_state_n = r_state;
        w_drop_n  = r_dropping;
        w_wr_en   = 1'b0;
        w_mark    = 1'b0;
        w_seq_n   = 1'b0;
        w_ovf_n   = 1'b0;
        if (w_multi) begin
            w_state_n = EXP1;
            w_seq_n   = 1'b1;
        end else if (w_commit) begin
            if (w_slot == 2'd0) begin
                if (w_wr_full) begin
                    w_ovf_n   = 1'b1;
                    w_drop_n  = 1'b1;
                    w_state_n = EXP1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_drop_n  = 1'b0;
                    w_state_n = EXP2;
                    w_seq_n   = (r_state != EXP1) && !r_dropping;
                end
            end else if (r_dropping) begin
                w_state_n = EXP1;
            end else if (w_slot == 2'(r_state)) begin
                w_wr_en = 1'b1;
                if (w_slot == 2'd3) begin
                    w_mark    = 1'b1;
                    w_state_n = EXP1;
                end else begin
                    w_state_n = cap_state_e'(w_slot + 2'd1);
                end
            end else begin
                w_seq_n   = 1'b1;
                w_state_n = EXP1;
            end
        end else begin
            w_state_n = r_state;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EXP1;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Strobe history, hold register, drop mode, error pulses and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_d    <= 4'd0;
            r_hold      <= 8'd0;
            r_ignore    <= 1'b0;
            r_dropping  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_read_d   <= w_read;
            r_dropping <= w_drop_n;
            r_seq_err  <= w_seq_n;
            r_overflow <= w_ovf_n;
            if (w_read != 4'd0) begin
                r_hold <= DATA;
            end
            if (w_multi) begin
                r_ignore <= 1'b1;
            end else if (w_read == 4'd0) begin
                r_ignore <= 1'b0;
            end
            if (w_seq_n || w_ovf_n) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    pixel_frame_buf u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (w_wr_en),
        .i_wr_slot    (w_slot),
        .i_wr_data    (w_value),
        .i_mark_full  (w_mark),
        .o_wr_full    (w_wr_full),
        .i_out_ready  (out_ready),
        .o_out_valid  (out_valid),
        .o_out_data   (out_data),
        .o_out_chan   (out_chan),
        .o_out_first  (out_first),
        .o_out_last   (out_last),
        .o_frame_done (w_frame_done)
    );

    assign seq_err   = r_seq_err;
    assign overflow  = r_overflow;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
